// File: rtl/bcd_pkg.sv
// Shared constants, state type and sizing helper for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Decimal digits of 2**bin_w - 1, i.e. floor(bin_w * log10(2)) + 1.
  function automatic int bcd_digits_needed(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, keeping a 4-bit result.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH) begin
      digit_out = digit_in + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both sides.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIN_W-1:0]                  in_bin,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] out_bcd,
  output logic                              busy
);

  localparam int BCD_W = BCD_DIGIT_W * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  generate
    if (BIN_W < 1) begin : g_bad_bin_w
      $error("bcd_seq_converter: BIN_W must be at least 1");
    end
    if (BCD_DIGITS < bcd_digits_needed(BIN_W)) begin : g_bad_digits
      $error("bcd_seq_converter: BCD_DIGITS too small for BIN_W");
    end
  endgenerate

  bcd_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (bcd_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, then adjust-and-shift the joint register.
  always_comb begin
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (state_q == IDLE && in_valid) begin
      bin_d = in_bin;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (state_q == SHIFT) begin
      {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign out_bcd = bcd_q;

endmodule
